// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU issue stage and its users.
//   - aluControl code constants (ADD..SLT, MUL, DIV)
//   - issue-stage state encoding
//   - latency lookup and illegal-code helpers
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Cycles the ALU needs for a given code. Only MUL and DIV are multi-cycle;
  // everything else (including illegal codes) takes a single cycle.
  function automatic logic [4:0] op_latency(input logic [3:0] op,
                                            input int unsigned mul_lat,
                                            input int unsigned div_lat);
    logic [4:0] lat;
    lat = 5'd1;
    if (op == OP_MUL) lat = mul_lat[4:0];
    else if (op == OP_DIV) lat = div_lat[4:0];
    return lat;
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op >= 4'b1010;
  endfunction

endpackage

// File: rtl/alu_issue.sv
// alu_issue: single-entry issue/capture stage wrapped around an external ALU.
// Accepts one operation from decode, holds its operands on the ALU inputs for
// the operation's latency, captures the ALU result and offers it to writeback.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         decode handshake; in_a, in_b, in_op operation
//   alu_a, alu_b, alu_op      registered operands/code driven to the ALU
//   alu_out, alu_zero         ALU result and zero flag
//   out_valid/out_ready       writeback handshake
//   out_data, out_zero        captured result and zero flag
//   out_illegal, out_divz     captured illegal-code and divide-by-zero flags
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 16,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [3:0]  in_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_zero,
  output logic        out_illegal,
  output logic        out_divz
);

  state_t      state_q,       state_d;
  logic [4:0]  cnt_q,         cnt_d;
  logic [15:0] alu_a_q,       alu_a_d;
  logic [15:0] alu_b_q,       alu_b_d;
  logic [3:0]  alu_op_q,      alu_op_d;
  logic [15:0] out_data_q,    out_data_d;
  logic        out_zero_q,    out_zero_d;
  logic        out_illegal_q, out_illegal_d;
  logic        out_divz_q,    out_divz_d;
  logic        accept;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    out_data_d    = out_data_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
    out_divz_d    = out_divz_q;

    case (state_q)
      ST_IDLE: ;
      ST_EXEC: begin
        // The counter is loaded with L and counts down once per EXEC edge.
        // Capture happens one edge after it would reach the "last" cycle,
        // because the ALU result only settles a cycle after its operands are
        // registered: this places out_valid L+1 edges after the accept.
        if (cnt_q == 5'd0) begin
          state_d = ST_DONE;
          if (op_is_illegal(alu_op_q)) begin
            out_data_d    = 16'h0000;
            out_zero_d    = 1'b1;
            out_illegal_d = 1'b1;
            out_divz_d    = 1'b0;
          end else if ((alu_op_q == OP_DIV) && (alu_b_q == 16'h0000)) begin
            out_data_d    = 16'hFFFF;
            out_zero_d    = 1'b0;
            out_illegal_d = 1'b0;
            out_divz_d    = 1'b1;
          end else begin
            out_data_d    = alu_out;
            out_zero_d    = alu_zero;
            out_illegal_d = 1'b0;
            out_divz_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the DONE->IDLE transition so a pending op issues on
    // the same edge that hands off the previous result.
    if (accept) begin
      state_d  = ST_EXEC;
      alu_a_d  = in_a;
      alu_b_d  = in_b;
      alu_op_d = in_op;
      cnt_d    = op_latency(in_op, MUL_LAT, DIV_LAT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 5'd0;
      alu_a_q       <= 16'h0000;
      alu_b_q       <= 16'h0000;
      alu_op_q      <= OP_ADD;
      out_data_q    <= 16'h0000;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
      out_divz_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      out_data_q    <= out_data_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
      out_divz_q    <= out_divz_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign out_valid   = (state_q == ST_DONE);
  assign out_data    = out_data_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;
  assign out_divz    = out_divz_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue with an ALU model attached
// and a reference model that predicts result, flags and latency per operation.
module tb_alu_issue;

  localparam int MUL_LAT = 16;
  localparam int DIV_LAT = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_illegal;
  logic        out_divz;

  int n_total = 0;
  int n_bad   = 0;

  alu_issue #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero),
    .out_illegal(out_illegal), .out_divz(out_divz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU attached to the issue stage (the environment).
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = alu_a ^ alu_b;
      4'd5: alu_out = alu_a << alu_b[3:0];
      4'd6: alu_out = alu_a >> alu_b[3:0];
      4'd7: alu_out = (alu_a < alu_b) ? 16'd1 : 16'd0;
      4'd8: alu_out = alu_a * alu_b;
      4'd9: alu_out = (alu_b != 16'd0) ? (alu_a / alu_b) : 16'h1234;
      default: alu_out = 16'hBEEF;
    endcase
    alu_zero = (alu_out == 16'h0000);
  end

  typedef struct packed {
    logic [15:0] data;
    logic        zero;
    logic        ill;
    logic        divz;
  } exp_t;

  // Expected captured result for an operation, from the operation's meaning.
  function automatic exp_t ref_result(input int unsigned a, input int unsigned b,
                                      input int unsigned op);
    exp_t e;
    int unsigned r;
    r = 0;
    e.ill = 1'b0;
    e.divz = 1'b0;
    if (op >= 10) begin
      e.ill = 1'b1;
      r = 0;
    end else if (op == 9 && b == 0) begin
      e.divz = 1'b1;
      r = 'hFFFF;
    end else begin
      case (op)
        0: r = a + b;
        1: r = a + 'h10000 - b;
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = a * (1 << (b % 16));
        6: r = a / (1 << (b % 16));
        7: r = (a < b) ? 1 : 0;
        8: r = a * b;
        default: r = a / b;
      endcase
    end
    r = r % 'h10000;
    e.data = r[15:0];
    e.zero = e.ill ? 1'b1 : (e.divz ? 1'b0 : (r == 0));
    return e;
  endfunction

  // Edges from accept to out_valid.
  function automatic int ref_lat(input int unsigned op);
    if (op == 8) return MUL_LAT + 1;
    if (op == 9) return DIV_LAT + 1;
    return 2;
  endfunction

  // Drives one op from IDLE and waits for out_valid (bounded). lat is the
  // number of edges after the accept edge at which out_valid was seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input bit noise,
                        output int lat, output int leaks, output int unstable);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; leaks = 0; unstable = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) leaks++;
      if (alu_a !== a || alu_b !== b || alu_op !== op) unstable++;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = 16'($urandom); in_b = 16'($urandom); in_op = 4'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 16'h0; in_b = 16'h0; in_op = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, out_data, out_zero, out_illegal, out_divz} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b d=%h z=%b i=%b dz=%b want all 0",
               out_valid, out_data, out_zero, out_illegal, out_divz);
    end
    n_total++;
    if ({alu_a, alu_b, alu_op} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_alu: got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op);
    end
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, leaks, unst;
    run_op(16'd3, 16'd4, 4'b0000, 1'b0, lat, leaks, unst);
    n_total++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL add_lat: got %0d want 2", lat);
    end
    n_total++;
    if ({out_data, out_zero, out_illegal, out_divz} !== {16'd7, 3'b000}) begin
      n_bad++;
      $display("FAIL add_result: got d=%0d z=%b i=%b dz=%b want d=7 z=0 i=0 dz=0",
               out_data, out_zero, out_illegal, out_divz);
    end
    pop();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL add_pop: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_mul();
    int lat, leaks, unst;
    run_op(16'd300, 16'd5, 4'b1000, 1'b0, lat, leaks, unst);
    n_total++;
    if (lat !== 17 || leaks !== 0) begin
      n_bad++; $display("FAIL mul_timing: got lat=%0d ready_hi=%0d want lat=17 ready_hi=0", lat, leaks);
    end
    n_total++;
    if (out_data !== 16'd1500 || out_zero !== 1'b0) begin
      n_bad++; $display("FAIL mul_result: got d=%0d z=%b want d=1500 z=0", out_data, out_zero);
    end
    pop();
  endtask

  task automatic test_divz();
    int lat, leaks, unst;
    run_op(16'd9, 16'd0, 4'b1001, 1'b0, lat, leaks, unst);
    n_total++;
    if (lat !== DIV_LAT + 1) begin
      n_bad++; $display("FAIL divz_lat: got %0d want %0d", lat, DIV_LAT + 1);
    end
    n_total++;
    if ({out_data, out_zero, out_illegal, out_divz} !== {16'hFFFF, 3'b001}) begin
      n_bad++;
      $display("FAIL divz_result: got d=%h z=%b i=%b dz=%b want d=ffff z=0 i=0 dz=1",
               out_data, out_zero, out_illegal, out_divz);
    end
    pop();
  endtask

  task automatic test_illegal();
    int lat, leaks, unst;
    run_op(16'd77, 16'd88, 4'b1100, 1'b0, lat, leaks, unst);
    n_total++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL ill_lat: got %0d want 2", lat);
    end
    n_total++;
    if ({out_data, out_zero, out_illegal, out_divz} !== {16'h0, 3'b110}) begin
      n_bad++;
      $display("FAIL ill_result: got d=%h z=%b i=%b dz=%b want d=0 z=1 i=1 dz=0",
               out_data, out_zero, out_illegal, out_divz);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    int lat, leaks, unst, n;
    run_op(16'd20, 16'd22, 4'b0000, 1'b0, lat, leaks, unst);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++;
      if ({out_valid, out_data, out_zero, out_illegal, out_divz} !== {1'b1, 16'd42, 3'b000}) begin
        n_bad++;
        $display("FAIL hold_%0d: got v=%b d=%0d z=%b i=%b dz=%b want v=1 d=42 flags 0",
                 i, out_valid, out_data, out_zero, out_illegal, out_divz);
      end
    end
    in_a = 16'd10; in_b = 16'd4; in_op = 4'b0001; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || alu_op !== 4'b0001 || alu_a !== 16'd10 || alu_b !== 16'd4) begin
      n_bad++;
      $display("FAIL b2b_accept: got v=%b op=%h a=%0d b=%0d want v=0 op=1 a=10 b=4",
               out_valid, alu_op, alu_a, alu_b);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_total++;
    if (n !== 2 || out_data !== 16'd6) begin
      n_bad++; $display("FAIL b2b_result: got edges=%0d d=%0d want edges=2 d=6", n, out_data);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int seen, lat, leaks, unst;
    exp_t e;
    in_a = 16'd300; in_b = 16'd5; in_op = 4'b1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, out_data, out_zero, out_illegal, out_divz, alu_a, alu_b, alu_op} !== 56'h0) begin
      n_bad++;
      $display("FAIL rstmid_out: got v=%b d=%h a=%h b=%h op=%h want all 0",
               out_valid, out_data, alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_total++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL rstmid_quiet: got %0d valid cycles want 0", seen);
    end
    e = ref_result(1234, 4321, 0);
    run_op(16'd1234, 16'd4321, 4'b0000, 1'b0, lat, leaks, unst);
    n_total++;
    if (lat !== 2 || out_data !== e.data) begin
      n_bad++; $display("FAIL rstmid_recover: got lat=%0d d=%h want lat=2 d=%h", lat, out_data, e.data);
    end
    pop();
  endtask

  task automatic test_random();
    int lat, leaks, unst, hold;
    logic [15:0] a, b;
    logic [3:0] op;
    exp_t e;
    for (int t = 0; t < 40; t++) begin
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(0, 20));
      op = 4'($urandom_range(0, 15));
      e  = ref_result(a, b, op);
      run_op(a, b, op, 1'b1, lat, leaks, unst);
      n_total++;
      if (lat !== ref_lat(op) || leaks !== 0 || unst !== 0) begin
        n_bad++;
        $display("FAIL rnd%0d_timing op=%h: got lat=%0d ready_hi=%0d unstable=%0d want lat=%0d 0 0",
                 t, op, lat, leaks, unst, ref_lat(op));
      end
      n_total++;
      if ({out_data, out_zero, out_illegal, out_divz} !== {e.data, e.zero, e.ill, e.divz}) begin
        n_bad++;
        $display("FAIL rnd%0d_result a=%h b=%h op=%h: got d=%h z=%b i=%b dz=%b want d=%h z=%b i=%b dz=%b",
                 t, a, b, op, out_data, out_zero, out_illegal, out_divz,
                 e.data, e.zero, e.ill, e.divz);
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
      end
      n_total++;
      if (out_valid !== 1'b1 || out_data !== e.data) begin
        n_bad++; $display("FAIL rnd%0d_hold: got v=%b d=%h want v=1 d=%h", t, out_valid, out_data, e.data);
      end
      pop();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_divz();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
